// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, NOP-forcing of side-effecting control bits and a bubble counter.
module idex_stage_reg #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 10,
    parameter int                 REG_AW    = 5,
    parameter int                 CTRL_W    = 11,
    parameter logic [CTRL_W-1:0]  KILL_MASK = 11'h51E,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] in_sign10,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_sign32,
    input  logic [REG_AW-1:0] in_wreg1,
    input  logic [REG_AW-1:0] in_wreg2,
    input  logic [REG_AW-1:0] in_src,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] out_sign10,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_sign32,
    output logic [REG_AW-1:0] out_wreg1,
    output logic [REG_AW-1:0] out_wreg2,
    output logic [REG_AW-1:0] out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int BW = CTRL_W + 2*ADDR_W + 3*DATA_W + 3*REG_AW;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     in_bundle, main_p1, skid_p1;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_valid, skid_valid;
    logic              accept, consume;
    logic              load_main, main_from_skid, load_skid;

    assign in_bundle = {in_ctrl, in_addr, in_sign10, in_data1, in_data2, in_sign32,
                        in_wreg1, in_wreg2, in_src};
    assign {main_ctrl, out_addr, out_sign10, out_data1, out_data2, out_sign32,
            out_wreg1, out_wreg2, out_src} = main_p1;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == TWO);
    assign out_valid  = main_valid;
    assign in_ready   = !skid_valid;
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;

    assign out_ctrl = main_ctrl & ~(KILL_MASK & {CTRL_W{~out_valid}});

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end
            end
            TWO: begin
                if (consume) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush only clears the valids; held data stays put and offers are dropped.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_main)           main_p1 <= in_bundle;
            else if (main_from_skid) main_p1 <= skid_p1;
            if (load_skid)           skid_p1 <= in_bundle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (cnt_clr)
            bubble_cnt <= '0;
        else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Randomized and directed bench for idex_stage_reg against a queue-based FIFO model.
module tb_idex_stage_reg;

    localparam int CNT_W = 4;
    localparam logic [10:0] KILL = 11'h51E;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [9:0]  addr;
        logic [9:0]  sign10;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] sign32;
        logic [4:0]  wreg1;
        logic [4:0]  wreg2;
        logic [4:0]  src;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n, flush, cnt_clr, in_valid, out_ready;
    bundle_t drv;
    logic        in_ready, out_valid;
    logic [10:0] out_ctrl;
    logic [9:0]  out_addr, out_sign10;
    logic [31:0] out_data1, out_data2, out_sign32;
    logic [4:0]  out_wreg1, out_wreg2, out_src;
    logic [CNT_W-1:0] bubble_cnt;

    always #5 clk = ~clk;

    idex_stage_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(drv.ctrl), .in_addr(drv.addr), .in_sign10(drv.sign10),
        .in_data1(drv.data1), .in_data2(drv.data2), .in_sign32(drv.sign32),
        .in_wreg1(drv.wreg1), .in_wreg2(drv.wreg2), .in_src(drv.src),
        .out_ctrl(out_ctrl), .out_addr(out_addr), .out_sign10(out_sign10),
        .out_data1(out_data1), .out_data2(out_data2), .out_sign32(out_sign32),
        .out_wreg1(out_wreg1), .out_wreg2(out_wreg2), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready), .bubble_cnt(bubble_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: FIFO of up to two bundles, the bundle last presented at the output,
    // and a saturating idle-cycle counter.
    bundle_t q[$];
    bundle_t shown;
    int      m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.ctrl   = 11'($urandom);
        b.addr   = 10'($urandom);
        b.sign10 = 10'($urandom);
        b.data1  = $urandom;
        b.data2  = $urandom;
        b.sign32 = $urandom;
        b.wreg1  = 5'($urandom);
        b.wreg2  = 5'($urandom);
        b.src    = 5'($urandom);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        shown = '0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit pre_valid, pre_ready;
        pre_valid = (q.size() > 0);
        pre_ready = (q.size() < 2);
        if (cnt_clr) m_cnt = 0;
        else if (!pre_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (pre_valid && out_ready) void'(q.pop_front());
        if (flush) q.delete();
        else begin
            if (in_valid && pre_ready) q.push_back(drv);
            if (q.size() > 0) shown = q[0];
        end
    endtask

    task automatic compare_all();
        bit ev;
        ev = (q.size() > 0);
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_ctrl", out_ctrl, ev ? shown.ctrl : (shown.ctrl & ~KILL));
        chk("out_addr", out_addr, shown.addr);
        chk("out_sign10", out_sign10, shown.sign10);
        chk("out_data1", out_data1, shown.data1);
        chk("out_data2", out_data2, shown.data2);
        chk("out_sign32", out_sign32, shown.sign32);
        chk("out_wreg1", out_wreg1, shown.wreg1);
        chk("out_wreg2", out_wreg2, shown.wreg2);
        chk("out_src", out_src, shown.src);
        chk("bubble_cnt", bubble_cnt, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv = rand_bundle();
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] one;
        rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drv = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Back-to-back stream with a consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drv = rand_bundle();
            drv.data1 = i;
            step();
            chk("stream_data1", out_data1, i);
            chk("stream_ready", in_ready, 1'b1);
        end
        idle(2);

        // Backpressure: A, B held, C refused until space frees up.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drv = rand_bundle(); drv.data1 = 32'hA; step();
        drv = rand_bundle(); drv.data1 = 32'hB; step();
        chk("bp_ready_after_b", in_ready, 1'b0);
        drv = rand_bundle(); drv.data1 = 32'hC; step();
        chk("bp_hold_a", out_data1, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data1, 32'hB);
        step();
        chk("bp_out_c", out_data1, 32'hC);
        in_valid = 1'b0;
        step();
        chk("bp_drained", out_valid, 1'b0);

        // Flush in TWO with an offer present.
        fill_two();
        flush    = 1'b1;
        in_valid = 1'b1;
        drv = rand_bundle(); drv.data1 = 32'hDEAD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_kill", out_ctrl & KILL, 11'h0);
        chk("flush_ready", in_ready, 1'b1);
        idle(3);

        // Walking one through the control word.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        one = 11'd1;
        for (int i = 0; i < 11; i++) begin
            drv = rand_bundle();
            drv.ctrl = one << i;
            drv.src = 5'h1F;
            drv.wreg2 = 5'h15;
            step();
            chk("walk_ctrl", out_ctrl, one << i);
            chk("walk_src", out_src, 5'h1F);
            chk("walk_wreg2", out_wreg2, 5'h15);
        end

        // Bubble counter saturation and clear while idle.
        idle(20);
        chk("cnt_sat", bubble_cnt, 4'hF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_idle", bubble_cnt, 4'h0);

        // Asynchronous reset while holding two bundles.
        fill_two();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", out_valid, 1'b0);
        chk("areset_ready", in_ready, 1'b1);
        chk("areset_ctrl", out_ctrl, 11'h0);
        chk("areset_cnt", bubble_cnt, 4'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drv       = rand_bundle();
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 5);
            cnt_clr   = ($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0; cnt_clr = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
